serial_adder: RTL and testbench

- Parametrised, multi-cycle add/subtract engine. It succeeds the combinational half adder: it generalises operand width and adds carry-in, a subtract mode, overflow detection and a start/done handshake.
- Processes BPC bits per clock using a registered carry. Latency trades against adder area.
- Used as a small-area arithmetic unit wherever a single-cycle WIDTH-bit adder is too large or timing-critical.

---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract engine: consumes BPC operand bits per clock through a
// registered carry and reports sum, raw carry-out and signed overflow on a done pulse.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("serial_adder: BPC must be >= 1 and divide WIDTH (>= 2) exactly");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       res;
    logic                   carry;
    logic [CW-1:0]          step;

    logic [BPC:0]           slice;
    logic [WIDTH+BPC-1:0]   res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   msb_cin;
    logic                   last;

    // Overflow: carry into the sign bit disagrees with carry out of it.
    function automatic logic ovf_of(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    always_comb begin
        slice    = {1'b0, opa[BPC-1:0]} + {1'b0, opb[BPC-1:0]} + {{BPC{1'b0}}, carry};
        res_cat  = {slice[BPC-1:0], res} >> BPC;
        res_next = res_cat[WIDTH-1:0];
        msb_cin  = opa[BPC-1] ^ opb[BPC-1] ^ slice[BPC-1];
        last     = (step == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            step  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow through the same adder.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        res   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> BPC;
                    opb   <= opb >> BPC;
                    res   <= res_next;
                    carry <= slice[BPC];
                    step  <= step + 1'b1;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= slice[BPC];
                        ovf   <= ovf_of(msb_cin, slice[BPC]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four parameterisations driven in parallel, checked each
// cycle against an arithmetic reference model plus directed literal expectations.
module tb_serial_adder;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;

    logic [3:0]  dbusy, ddone, dcout, dovf;
    logic [15:0] dsum [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Configurations: (8,1) (8,4) (8,8) (16,2)
    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W = (g == 3) ? 16 : 8;
        localparam int B = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 2;
        logic         busy, done, cout, ovf;
        logic [W-1:0] sum;
        serial_adder #(.WIDTH(W), .BPC(B)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
            .a(a[W-1:0]), .b(b[W-1:0]), .cin(cin),
            .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
        );
        assign dbusy[g] = busy;
        assign ddone[g] = done;
        assign dcout[g] = cout;
        assign dovf[g]  = ovf;
        assign dsum[g]  = 16'(sum);
    end

    function automatic int wid(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic int lat(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    // Reference arithmetic from the add/subtract definition itself.
    function automatic void ref_op(input int w, input bit s, input int av_in, input int bv_in,
                                   input bit c, output int rs, output bit rc, output bit ro);
        int mask, av, bv, full, ex;
        mask = (1 << w) - 1;
        av   = av_in & mask;
        bv   = bv_in & mask;
        if (!s) begin
            full = av + bv + int'(c);
            rc   = ((full >> w) & 1) != 0;
            ex   = sx(av, w) + sx(bv, w) + int'(c);
        end else begin
            full = av - bv - int'(c);
            rc   = (full >= 0);
            ex   = sx(av, w) - sx(bv, w) - int'(c);
        end
        rs = full & mask;
        ro = (ex < -(1 << (w - 1))) || (ex > (1 << (w - 1)) - 1);
    endfunction

    bit ebusy [4];
    bit edone [4];
    bit ecout [4];
    bit eovf  [4];
    int esum  [4];
    int left  [4];
    int psum  [4];
    bit pcout [4];
    bit povf  [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ebusy[i] = 0; edone[i] = 0; ecout[i] = 0; eovf[i] = 0;
                esum[i]  = 0; left[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                edone[i] = 0;
                if (ebusy[i]) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        ebusy[i] = 0;
                        edone[i] = 1;
                        esum[i]  = psum[i];
                        ecout[i] = pcout[i];
                        eovf[i]  = povf[i];
                    end
                end else if (start) begin
                    ref_op(wid(i), sub, int'(a), int'(b), cin, psum[i], pcout[i], povf[i]);
                    left[i]  = lat(i);
                    ebusy[i] = 1;
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("busy[%0d]", i), int'(dbusy[i]), int'(ebusy[i]));
            check($sformatf("done[%0d]", i), int'(ddone[i]), int'(edone[i]));
            check($sformatf("sum[%0d]",  i), int'(dsum[i]),  esum[i]);
            check($sformatf("cout[%0d]", i), int'(dcout[i]), int'(ecout[i]));
            check($sformatf("ovf[%0d]",  i), int'(dovf[i]),  int'(eovf[i]));
        end
    end

    // Called on a falling edge; that edge is the one start is presented on.
    task automatic run_op(input bit s, input int av, input int bv, input bit c,
                          input int xs, input bit xc, input bit xo, input string nm);
        int k;
        sub = s; a = 16'(av); b = 16'(bv); cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!ddone[0] && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, k, 9);
        check({nm, "_sum"},  int'(dsum[0]),  xs);
        check({nm, "_cout"}, int'(dcout[0]), int'(xc));
        check({nm, "_ovf"},  int'(dovf[0]),  int'(xo));
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", int'(dbusy[0]), 0);
        check("reset_sum",  int'(dsum[0]),  0);

        run_op(1'b0, 'h3C, 'h5A, 1'b0, 'h96, 1'b0, 1'b1, "add");
        run_op(1'b0, 'hFF, 'h01, 1'b0, 'h00, 1'b1, 1'b0, "wrap_ff");
        run_op(1'b0, 'h7F, 'h00, 1'b1, 'h80, 1'b0, 1'b1, "wrap_7f");
        run_op(1'b1, 'h10, 'h20, 1'b0, 'hF0, 1'b0, 1'b0, "sub_neg");
        run_op(1'b1, 'h80, 'h01, 1'b0, 'h7F, 1'b1, 1'b1, "sub_ovf");

        // start while busy must be ignored by the 8-cycle unit
        sub = 1'b0; a = 16'h3C; b = 16'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 16'h01; b = 16'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!ddone[0] && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("busy_start_latency", k, 5);
        check("busy_start_sum", int'(dsum[0]), 'h96);
        run_op(1'b0, 'h01, 'h01, 1'b0, 'h02, 1'b0, 1'b0, "back_to_back");

        // asynchronous reset mid-operation
        sub = 1'b0; a = 16'h3C; b = 16'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_busy[%0d]", i), int'(dbusy[i]), 0);
            check($sformatf("async_rst_done[%0d]", i), int'(ddone[i]), 0);
            check($sformatf("async_rst_sum[%0d]",  i), int'(dsum[i]),  0);
            check($sformatf("async_rst_cout[%0d]", i), int'(dcout[i]), 0);
            check($sformatf("async_rst_ovf[%0d]",  i), int'(dovf[i]),  0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 'h3C, 'h5A, 1'b0, 'h96, 1'b0, 1'b1, "after_reset");

        for (int n = 0; n < 1000; n++) begin
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            while ((ebusy[0] | ebusy[1] | ebusy[2] | ebusy[3]) && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) check("random_timeout", 1, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
